// File: rtl/spi_slave_mopshub_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_mopshub_if
// Brief    : User byte port and SPI pad signals of the MOPSHUB SPI slave.
// Revision : 1.0
// ============================================================================
interface spi_slave_mopshub_if;
  logic [7:0] i_TX_Byte;
  logic       i_TX_DV;
  logic       o_TX_Ready;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_TX_Underrun;
  logic       o_Frame_Err;
  logic       i_SPI_Clk;
  logic       i_SPI_CS_n;
  logic       i_SPI_MOSI;
  logic       o_SPI_MISO;
  logic       o_SPI_MISO_En;

  modport slave (
    input  i_TX_Byte, i_TX_DV, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
    output o_TX_Ready, o_RX_DV, o_RX_Byte, o_TX_Underrun, o_Frame_Err,
           o_SPI_MISO, o_SPI_MISO_En
  );

  modport master (
    output i_TX_Byte, i_TX_DV, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
    input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_TX_Underrun, o_Frame_Err,
           o_SPI_MISO, o_SPI_MISO_En
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_mopshub.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_mopshub
// Brief    : Oversampling SPI slave, MSB-first, one-byte TX holding register.
// Revision : 1.0
// ============================================================================
module spi_slave_mopshub #(
  parameter int         SPI_MODE   = 3,
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  wire logic              i_Clk,
  input  wire logic              i_Rst,
  spi_slave_mopshub_if.slave     bus
);

  localparam logic [1:0] MODE_BITS      = SPI_MODE[1:0];
  localparam logic       CPOL           = MODE_BITS[1];
  localparam logic       CPHA           = MODE_BITS[0];
  localparam logic       SAMPLE_ON_RISE = (CPOL == CPHA);

  // HOLDOFF keeps a CS_n that was already low across reset from counting as a fresh assertion.
  typedef enum logic [1:0] {
    ST_HOLDOFF = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [1:0] settle_q, settle_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sr_q, rx_sr_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dv_q, rx_dv_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic       miso_q, miso_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       underrun_q, underrun_d;
  logic       frame_err_q, frame_err_d;

  logic       cs_n, mosi_s, sclk_rise, sclk_fall, selected;
  logic       sample_edge, shift_edge, cs_assert, cs_deassert;
  logic       byte_done, boundary, tx_accept;
  logic [7:0] load_val;

  assign cs_n        = cs_sync_q[1];
  assign mosi_s      = mosi_sync_q[1];
  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign selected    = (state_q == ST_ACTIVE) && !cs_n;
  assign sample_edge = selected && (SAMPLE_ON_RISE ? sclk_rise : sclk_fall);
  assign shift_edge  = selected && (SAMPLE_ON_RISE ? sclk_fall : sclk_rise);
  assign cs_assert   = (state_q == ST_IDLE) && !cs_n;
  assign cs_deassert = (state_q == ST_ACTIVE) && cs_n;
  assign byte_done   = sample_edge && (bit_cnt_q == 3'd7);
  assign boundary    = cs_assert || byte_done;
  assign tx_accept   = bus.i_TX_DV && !hold_full_q;
  assign load_val    = hold_full_q ? hold_q : DEFAULT_TX;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], bus.i_SPI_Clk};
    cs_sync_d   = {cs_sync_q[0], bus.i_SPI_CS_n};
    mosi_sync_d = {mosi_sync_q[0], bus.i_SPI_MOSI};
    state_d     = state_q;
    settle_d    = settle_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_HOLDOFF: begin
        if (settle_q != 2'd3) settle_d = settle_q + 2'd1;
        else if (cs_n)        state_d  = ST_IDLE;
      end
      ST_IDLE:   if (!cs_n) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_n)  state_d = ST_IDLE;
      default:   state_d = ST_HOLDOFF;
    endcase

    if (sample_edge) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_sr_d   = {rx_sr_q[5:0], mosi_s};
      if (byte_done) begin
        rx_byte_d = {rx_sr_q, mosi_s};
        rx_dv_d   = 1'b1;
      end
    end

    // With CPHA=0 bit 7 is already on MISO, so the shift edge closing a byte must not advance.
    if (shift_edge && (CPHA || (bit_cnt_q != 3'd0))) begin
      miso_d  = tx_sr_q[7];
      tx_sr_d = {tx_sr_q[6:0], 1'b0};
    end

    if (boundary) begin
      underrun_d = !hold_full_q;
      if (CPHA) begin
        tx_sr_d = load_val;
      end else begin
        miso_d  = load_val[7];
        tx_sr_d = {load_val[6:0], 1'b0};
      end
    end

    if (tx_accept) hold_d = bus.i_TX_Byte;
    if (boundary)       hold_full_d = tx_accept;
    else if (tx_accept) hold_full_d = 1'b1;

    if (cs_deassert) begin
      bit_cnt_d   = 3'd0;
      frame_err_d = (bit_cnt_q != 3'd0);
      tx_sr_d     = DEFAULT_TX;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= ST_HOLDOFF;
      sclk_sync_q <= {3{CPOL}};
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      settle_q    <= 2'd0;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 7'd0;
      rx_byte_q   <= 8'd0;
      rx_dv_q     <= 1'b0;
      tx_sr_q     <= DEFAULT_TX;
      miso_q      <= 1'b1;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      settle_q    <= settle_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.o_TX_Ready    = ~hold_full_q;
  assign bus.o_RX_DV       = rx_dv_q;
  assign bus.o_RX_Byte     = rx_byte_q;
  assign bus.o_TX_Underrun = underrun_q;
  assign bus.o_Frame_Err   = frame_err_q;
  assign bus.o_SPI_MISO    = miso_q;
  assign bus.o_SPI_MISO_En = ~cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_mopshub.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_mopshub
// Brief    : Scoreboard bench: mode-3 and mode-0 slaves driven by a bench SPI master.
// Revision : 1.0
// ============================================================================
module tb_spi_slave_mopshub;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_mopshub_if if3 ();
  spi_slave_mopshub_if if0 ();

  spi_slave_mopshub #(.SPI_MODE(3), .DEFAULT_TX(8'hFF)) dut3 (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (if3.slave)
  );

  spi_slave_mopshub #(.SPI_MODE(0), .DEFAULT_TX(8'hFF)) dut0 (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (if0.slave)
  );

  int checks = 0;
  int errors = 0;
  int rx_cnt   [4];
  int und_cnt  [4];
  int ferr_cnt [4];
  int und_snap = 0;
  logic [7:0] exp_rx3  [$];
  logic [7:0] exp_rx0  [$];
  logic [7:0] exp_miso [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sck(input int m, input logic v);
    if (m == 3) if3.i_SPI_Clk = v; else if0.i_SPI_Clk = v;
  endtask

  task automatic set_cs(input int m, input logic v);
    if (m == 3) if3.i_SPI_CS_n = v; else if0.i_SPI_CS_n = v;
  endtask

  task automatic set_mosi(input int m, input logic v);
    if (m == 3) if3.i_SPI_MOSI = v; else if0.i_SPI_MOSI = v;
  endtask

  function automatic logic get_miso(input int m);
    return (m == 3) ? if3.o_SPI_MISO : if0.o_SPI_MISO;
  endfunction

  function automatic logic get_ready(input int m);
    return (m == 3) ? if3.o_TX_Ready : if0.o_TX_Ready;
  endfunction

  function automatic logic [13:0] get_outs(input int m);
    if (m == 3)
      return {if3.o_TX_Ready, if3.o_RX_DV, if3.o_RX_Byte, if3.o_TX_Underrun,
              if3.o_Frame_Err, if3.o_SPI_MISO, if3.o_SPI_MISO_En};
    return {if0.o_TX_Ready, if0.o_RX_DV, if0.o_RX_Byte, if0.o_TX_Underrun,
            if0.o_Frame_Err, if0.o_SPI_MISO, if0.o_SPI_MISO_En};
  endfunction

  task automatic check_reset(input int m, input string tag);
    logic [13:0] o;
    o = get_outs(m);
    check({tag, "_tx_ready"}, 32'(o[13]), 32'd1);
    check({tag, "_rx_dv"},    32'(o[12]), 32'd0);
    check({tag, "_rx_byte"},  32'(o[11:4]), 32'd0);
    check({tag, "_underrun"}, 32'(o[3]), 32'd0);
    check({tag, "_frame_err"},32'(o[2]), 32'd0);
    check({tag, "_miso"},     32'(o[1]), 32'd1);
    check({tag, "_miso_en"},  32'(o[0]), 32'd0);
  endtask

  task automatic tx_write(input int m, input logic [7:0] b);
    if (m == 3) begin if3.i_TX_Byte = b; if3.i_TX_DV = 1'b1; end
    else        begin if0.i_TX_Byte = b; if0.i_TX_DV = 1'b1; end
    wait_clk(1);
    if (m == 3) if3.i_TX_DV = 1'b0; else if0.i_TX_DV = 1'b0;
  endtask

  task automatic wait_ready(input int m, input int budget);
    int n = 0;
    while (!get_ready(m) && n < budget) begin
      wait_clk(1);
      n++;
    end
    check("ready_wait", 32'(get_ready(m)), 32'd1);
  endtask

  // Bench-side SPI master: dut 3 runs mode 3, dut 0 runs mode 0.
  task automatic spi_byte(input int m, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    logic cpol, cpha;
    logic [7:0] r;
    cpol = (m == 3);
    cpha = (m == 3);
    r = 8'h00;
    if (!cpha) begin
      set_mosi(m, tx[7]);
      wait_clk(HALF);
    end
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (cpha) begin
        set_sck(m, ~cpol);
        set_mosi(m, tx[i]);
        wait_clk(HALF);
        if (i == 0) und_snap = und_cnt[m];
        set_sck(m, cpol);
        r[i] = get_miso(m);
        wait_clk(HALF);
      end else begin
        if (i == 0) und_snap = und_cnt[m];
        set_sck(m, ~cpol);
        r[i] = get_miso(m);
        wait_clk(HALF);
        set_sck(m, cpol);
        if (i > 0) set_mosi(m, tx[i-1]);
        wait_clk(HALF);
      end
    end
    rx = r;
  endtask

  task automatic master_byte(input int m, input logic [7:0] tx);
    logic [7:0] r;
    spi_byte(m, tx, 8, r);
    check("miso_queued", 32'(exp_miso.size() != 0), 32'd1);
    if (exp_miso.size() != 0) check("miso_byte", 32'(r), 32'(exp_miso.pop_front()));
  endtask

  task automatic frame(input int m, input logic [7:0] tx);
    set_cs(m, 1'b0);
    wait_clk(6);
    master_byte(m, tx);
    wait_clk(6);
    set_cs(m, 1'b1);
    wait_clk(10);
  endtask

  always @(negedge clk) begin
    if (if3.o_RX_DV) begin
      rx_cnt[3]++;
      check("rx3_queued", 32'(exp_rx3.size() != 0), 32'd1);
      if (exp_rx3.size() != 0) check("rx3_byte", 32'(if3.o_RX_Byte), 32'(exp_rx3.pop_front()));
    end
    if (if0.o_RX_DV) begin
      rx_cnt[0]++;
      check("rx0_queued", 32'(exp_rx0.size() != 0), 32'd1);
      if (exp_rx0.size() != 0) check("rx0_byte", 32'(if0.o_RX_Byte), 32'(exp_rx0.pop_front()));
    end
    if (if3.o_TX_Underrun) und_cnt[3]++;
    if (if0.o_TX_Underrun) und_cnt[0]++;
    if (if3.o_Frame_Err)   ferr_cnt[3]++;
    if (if0.o_Frame_Err)   ferr_cnt[0]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, u, f;
    logic [7:0] rx1, rx2, rxp;
    foreach (rx_cnt[k]) begin rx_cnt[k] = 0; und_cnt[k] = 0; ferr_cnt[k] = 0; end
    if3.i_SPI_Clk = 1'b1; if3.i_SPI_CS_n = 1'b1; if3.i_SPI_MOSI = 1'b0;
    if3.i_TX_DV = 1'b0; if3.i_TX_Byte = 8'h00;
    if0.i_SPI_Clk = 1'b0; if0.i_SPI_CS_n = 1'b1; if0.i_SPI_MOSI = 1'b0;
    if0.i_TX_DV = 1'b0; if0.i_TX_Byte = 8'h00;
    wait_clk(3);
    check_reset(3, "por3");
    check_reset(0, "por0");
    rst = 1'b0;
    wait_clk(6);

    // Mode 3 loopback
    tx_write(3, 8'hA5);
    check("t1_ready_low", 32'(get_ready(3)), 32'd0);
    exp_miso.push_back(8'hA5);
    exp_rx3.push_back(8'hC1);
    r = rx_cnt[3]; u = und_cnt[3];
    frame(3, 8'hC1);
    check("t1_rx_dv_count", 32'(rx_cnt[3] - r), 32'd1);
    check("t1_underrun", 32'(und_snap - u), 32'd0);
    check("t1_rx_byte", 32'(if3.o_RX_Byte), 32'hC1);

    // Back-to-back with refill as o_TX_Ready rises
    tx_write(3, 8'h12);
    exp_miso.push_back(8'h12);
    exp_miso.push_back(8'h34);
    exp_rx3.push_back(8'hBE);
    exp_rx3.push_back(8'hEF);
    r = rx_cnt[3];
    set_cs(3, 1'b0);
    fork
      begin
        wait_clk(6);
        master_byte(3, 8'hBE);
        check("t2_ready_b1", 32'(get_ready(3)), 32'd1);
        master_byte(3, 8'hEF);
      end
      begin
        wait_ready(3, 40);
        tx_write(3, 8'h34);
      end
    join
    wait_clk(6);
    check("t2_ready_b2", 32'(get_ready(3)), 32'd1);
    set_cs(3, 1'b1);
    wait_clk(10);
    check("t2_rx_dv_count", 32'(rx_cnt[3] - r), 32'd2);

    // Underrun
    exp_miso.push_back(8'hFF);
    exp_rx3.push_back(8'h3C);
    u = und_cnt[3];
    frame(3, 8'h3C);
    check("t3_underrun", 32'(und_snap - u), 32'd1);
    check("t3_rx_byte", 32'(if3.o_RX_Byte), 32'h3C);

    // Abort after 5 bits
    r = rx_cnt[3]; f = ferr_cnt[3];
    set_cs(3, 1'b0);
    wait_clk(6);
    spi_byte(3, 8'hF0, 5, rxp);
    wait_clk(4);
    set_cs(3, 1'b1);
    wait_clk(10);
    check("t4_frame_err", 32'(ferr_cnt[3] - f), 32'd1);
    check("t4_no_rx_dv", 32'(rx_cnt[3] - r), 32'd0);
    check("t4_rx_byte_kept", 32'(if3.o_RX_Byte), 32'h3C);
    tx_write(3, 8'h7E);
    exp_miso.push_back(8'h7E);
    exp_rx3.push_back(8'h81);
    frame(3, 8'h81);
    check("t4_rx_after", 32'(if3.o_RX_Byte), 32'h81);
    check("t4_frame_err_once", 32'(ferr_cnt[3] - f), 32'd1);

    // Reset mid-byte
    set_cs(3, 1'b0);
    wait_clk(6);
    spi_byte(3, 8'hE7, 3, rxp);
    tx_write(3, 8'h55);
    #2 rst = 1'b1;
    #1 check_reset(3, "rst3");
    set_cs(3, 1'b1);
    wait_clk(2);
    rst = 1'b0;
    r = rx_cnt[3]; f = ferr_cnt[3];
    wait_clk(10);
    check("t5_no_rx_dv", 32'(rx_cnt[3] - r), 32'd0);
    check("t5_no_frame_err", 32'(ferr_cnt[3] - f), 32'd0);
    exp_miso.push_back(8'hFF);
    exp_rx3.push_back(8'h5A);
    frame(3, 8'h5A);
    check("t5_rx_byte", 32'(if3.o_RX_Byte), 32'h5A);

    // Mode 0 instance
    r = rx_cnt[0];
    tx_write(0, 8'h96);
    exp_miso.push_back(8'h96);
    exp_rx0.push_back(8'h69);
    set_cs(0, 1'b0);
    wait_clk(6);
    check("t6_miso_b7_a", 32'(if0.o_SPI_MISO), 32'd1);
    check("t6_miso_en", 32'(if0.o_SPI_MISO_En), 32'd1);
    master_byte(0, 8'h69);
    wait_clk(6);
    set_cs(0, 1'b1);
    wait_clk(10);
    tx_write(0, 8'h4B);
    exp_miso.push_back(8'h4B);
    exp_rx0.push_back(8'hB4);
    set_cs(0, 1'b0);
    wait_clk(6);
    check("t6_miso_b7_b", 32'(if0.o_SPI_MISO), 32'd0);
    master_byte(0, 8'hB4);
    wait_clk(6);
    set_cs(0, 1'b1);
    wait_clk(10);
    check("t6_rx_dv_count", 32'(rx_cnt[0] - r), 32'd2);
    check("t6_rx_byte", 32'(if0.o_RX_Byte), 32'hB4);

    check("rx3_drained", 32'(exp_rx3.size()), 32'd0);
    check("rx0_drained", 32'(exp_rx0.size()), 32'd0);
    check("miso_drained", 32'(exp_miso.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
